// File: rtl/tensor_core_mma_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tensor_core_mma_pipe_if                                         |
// | Brief    : Operand-beat and result handshake bundle for the MMA pipe.      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
interface tensor_core_mma_pipe_if #(
   parameter int DWIDTH = 16,
   parameter int LANES  = 4
);
   logic                      in_valid;
   logic                      in_ready;
   logic                      in_first;
   logic                      in_last;
   logic [LANES*DWIDTH-1:0]   A_in;
   logic [LANES*DWIDTH-1:0]   B_in;
   logic [DWIDTH-1:0]         C_in;
   logic                      out_valid;
   logic                      out_ready;
   logic [DWIDTH-1:0]         C_out;
   logic                      out_exc;
   logic                      out_seq_err;

   modport master (
      output in_valid, in_first, in_last, A_in, B_in, C_in, out_ready,
      input  in_ready, out_valid, C_out, out_exc, out_seq_err
   );

   modport slave (
      input  in_valid, in_first, in_last, A_in, B_in, C_in, out_ready,
      output in_ready, out_valid, C_out, out_exc, out_seq_err
   );
endinterface
`default_nettype wire

// File: rtl/tensor_core_mma_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tensor_core_mma_pipe                                            |
// | Brief    : Pipelined fp16 dot-product/accumulate engine, one beat/cycle.   |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tensor_core_mma_pipe #(
   parameter int DWIDTH = 16,
   parameter int LANES  = 4
) (
   input wire                    clk,
   input wire                    rst_n,
   tensor_core_mma_pipe_if.slave bus
);
   localparam int LOG2L = $clog2(LANES);
   localparam int NODES = 2 * LANES - 1;

   localparam logic [0:0] c_st_idle  = 1'b0;
   localparam logic [0:0] c_st_accum = 1'b1;

   // Returns {flag, result}; subnormals flush to zero, rounding is nearest-even.
   function automatic logic [DWIDTH:0] fp_mul(input logic [DWIDTH-1:0] a,
                                              input logic [DWIDTH-1:0] b);
      logic              sgn;
      logic [21:0]       p;
      logic [9:0]        m;
      logic              g;
      logic              st;
      logic [10:0]       mr;
      logic signed [7:0] e;
      logic [DWIDTH:0]   r;
      sgn = a[15] ^ b[15];
      p   = {11'd0, 1'b1, a[9:0]} * {11'd0, 1'b1, b[9:0]};
      e   = $signed({3'b000, a[14:10]}) + $signed({3'b000, b[14:10]}) - 8'sd15;
      if (p[21]) begin
         m  = p[20:11];
         g  = p[10];
         st = |p[9:0];
         e  = e + 8'sd1;
      end else begin
         m  = p[19:10];
         g  = p[9];
         st = |p[8:0];
      end
      mr = {1'b0, m} + {10'd0, g & (st | m[0])};
      if (mr[10]) e = e + 8'sd1;
      if (a[14:10] == 5'h1F || b[14:10] == 5'h1F) begin
         if ((a[14:10] == 5'h1F && |a[9:0]) || (b[14:10] == 5'h1F && |b[9:0]) ||
             a[14:10] == 5'd0 || b[14:10] == 5'd0)
            r = {1'b1, 16'h7E00};
         else
            r = {1'b1, sgn, 15'h7C00};
      end else if (a[14:10] == 5'd0 || b[14:10] == 5'd0) begin
         r = {1'b0, sgn, 15'h0000};
      end else if (e >= 8'sd31) begin
         r = {1'b1, sgn, 15'h7C00};
      end else if (e <= 8'sd0) begin
         r = {1'b1, sgn, 15'h0000};
      end else begin
         r = {1'b0, sgn, e[4:0], mr[9:0]};
      end
      return r;
   endfunction

   // Larger magnitude is aligned as x; three extra bits carry guard/round/sticky.
   function automatic logic [DWIDTH:0] fp_add(input logic [DWIDTH-1:0] a,
                                              input logic [DWIDTH-1:0] b);
      logic [DWIDTH-1:0] x;
      logic [DWIDTH-1:0] y;
      logic [4:0]        d;
      logic [13:0]       mx;
      logic [13:0]       my;
      logic [13:0]       ys;
      logic [13:0]       nn;
      logic [14:0]       s;
      logic [3:0]        lz;
      logic              found;
      logic              rup;
      logic [10:0]       mr;
      logic signed [7:0] e;
      logic [DWIDTH:0]   r;
      if (a[14:0] >= b[14:0]) begin
         x = a;
         y = b;
      end else begin
         x = b;
         y = a;
      end
      d  = x[14:10] - y[14:10];
      mx = {1'b1, x[9:0], 3'b000};
      my = {1'b1, y[9:0], 3'b000};
      if (d >= 5'd14) ys = 14'd1;
      else            ys = (my >> d) | {13'd0, |(my & ((14'd1 << d) - 14'd1))};
      s  = (x[15] ^ y[15]) ? ({1'b0, mx} - {1'b0, ys}) : ({1'b0, mx} + {1'b0, ys});
      e     = $signed({3'b000, x[14:10]});
      lz    = 4'd0;
      found = 1'b0;
      if (s[14]) begin
         nn = {s[14:2], s[1] | s[0]};
         e  = e + 8'sd1;
      end else begin
         for (int i = 13; i >= 0; i--) begin
            if (!found) begin
               if (s[i]) found = 1'b1;
               else      lz = lz + 4'd1;
            end
         end
         nn = s[13:0] << lz;
         e  = e - $signed({4'b0000, lz});
      end
      rup = nn[2] & (nn[1] | nn[0] | nn[3]);
      mr  = {1'b0, nn[12:3]} + {10'd0, rup};
      if (mr[10]) e = e + 8'sd1;
      if (x[14:10] == 5'h1F) begin
         if (|x[9:0] || (y[14:10] == 5'h1F && (|y[9:0] || x[15] != y[15])))
            r = {1'b1, 16'h7E00};
         else
            r = {1'b1, x[15], 15'h7C00};
      end else if (y[14:10] == 5'd0) begin
         if (x[14:10] == 5'd0) r = {1'b0, x[15] & y[15], 15'h0000};
         else                  r = {1'b0, x};
      end else if (!nn[13]) begin
         r = '0;
      end else if (e >= 8'sd31) begin
         r = {1'b1, x[15], 15'h7C00};
      end else if (e <= 8'sd0) begin
         r = {1'b1, x[15], 15'h0000};
      end else begin
         r = {1'b0, x[15], e[4:0], mr[9:0]};
      end
      return r;
   endfunction

   logic                    w_stall;
   logic                    r_s0_vld;
   logic                    r_s0_first;
   logic                    r_s0_last;
   logic [DWIDTH-1:0]       r_s0_c;
   logic [LANES*DWIDTH-1:0] r_s0_a;
   logic [LANES*DWIDTH-1:0] r_s0_b;

   // Heap-ordered tree: leaves LANES..NODES-1+1 are products, node 1 is the root.
   logic [DWIDTH-1:0]       r_node [1:NODES];
   logic                    r_nexc [1:NODES];
   wire  [DWIDTH-1:0]       w_node_nxt [1:NODES];
   wire                     w_nexc_nxt [1:NODES];

   logic                    r_sb_vld   [0:LOG2L];
   logic                    r_sb_first [0:LOG2L];
   logic                    r_sb_last  [0:LOG2L];
   logic [DWIDTH-1:0]       r_sb_c     [0:LOG2L];

   assign w_stall      = bus.out_valid && !bus.out_ready;
   assign bus.in_ready = !w_stall;

   for (genvar i = 0; i < LANES; i++) begin : g_lane
      wire [DWIDTH:0] w_prod;
      assign w_prod                = fp_mul(r_s0_a[i*DWIDTH +: DWIDTH], r_s0_b[i*DWIDTH +: DWIDTH]);
      assign w_node_nxt[LANES + i] = w_prod[DWIDTH-1:0];
      assign w_nexc_nxt[LANES + i] = w_prod[DWIDTH];
   end

   for (genvar p = 1; p < LANES; p++) begin : g_node
      wire [DWIDTH:0] w_sum;
      assign w_sum         = fp_add(r_node[2*p], r_node[2*p+1]);
      assign w_node_nxt[p] = w_sum[DWIDTH-1:0];
      assign w_nexc_nxt[p] = w_sum[DWIDTH] | r_nexc[2*p] | r_nexc[2*p+1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_s0_vld   <= 1'b0;
         r_s0_first <= 1'b0;
         r_s0_last  <= 1'b0;
         r_s0_c     <= '0;
         r_s0_a     <= '0;
         r_s0_b     <= '0;
         for (int k = 1; k <= NODES; k++) begin
            r_node[k] <= '0;
            r_nexc[k] <= 1'b0;
         end
         for (int l = 0; l <= LOG2L; l++) begin
            r_sb_vld[l]   <= 1'b0;
            r_sb_first[l] <= 1'b0;
            r_sb_last[l]  <= 1'b0;
            r_sb_c[l]     <= '0;
         end
      end else if (!w_stall) begin
         r_s0_vld   <= bus.in_valid;
         r_s0_first <= bus.in_first;
         r_s0_last  <= bus.in_last;
         r_s0_c     <= bus.C_in;
         r_s0_a     <= bus.A_in;
         r_s0_b     <= bus.B_in;
         for (int k = 1; k <= NODES; k++) begin
            r_node[k] <= w_node_nxt[k];
            r_nexc[k] <= w_nexc_nxt[k];
         end
         r_sb_vld[0]   <= r_s0_vld;
         r_sb_first[0] <= r_s0_first;
         r_sb_last[0]  <= r_s0_last;
         r_sb_c[0]     <= r_s0_c;
         for (int l = 1; l <= LOG2L; l++) begin
            r_sb_vld[l]   <= r_sb_vld[l-1];
            r_sb_first[l] <= r_sb_first[l-1];
            r_sb_last[l]  <= r_sb_last[l-1];
            r_sb_c[l]     <= r_sb_c[l-1];
         end
      end
   end

   logic              w_t_vld;
   logic              w_t_first;
   logic              w_t_last;
   logic [DWIDTH-1:0] w_t_c;
   assign w_t_vld   = r_sb_vld[LOG2L];
   assign w_t_first = r_sb_first[LOG2L];
   assign w_t_last  = r_sb_last[LOG2L];
   assign w_t_c     = r_sb_c[LOG2L];

   logic [0:0]        r_state;
   logic [0:0]        w_state_nxt;
   logic              w_start;
   logic [DWIDTH-1:0] w_seed;
   logic              w_err_nxt;
   logic [DWIDTH-1:0] r_acc;
   logic              r_exc_acc;
   logic              r_seq_err;
   wire  [DWIDTH:0]   w_acc_sum;
   logic              w_exc_nxt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)         r_state <= c_st_idle;
      else if (!w_stall)  r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (w_t_vld) w_state_nxt = w_t_last ? c_st_idle : c_st_accum;
   end

   // A headless beat in IDLE starts from +0; a first beat mid-sequence restarts.
   always_comb begin
      w_start   = 1'b1;
      w_seed    = w_t_first ? w_t_c : '0;
      w_err_nxt = !w_t_first;
      unique case (r_state)
         c_st_idle: begin
         end
         c_st_accum: begin
            if (w_t_first) begin
               w_err_nxt = 1'b1;
            end else begin
               w_start   = 1'b0;
               w_seed    = r_acc;
               w_err_nxt = r_seq_err;
            end
         end
      endcase
   end

   assign w_acc_sum = fp_add(w_seed, r_node[1]);
   assign w_exc_nxt = (!w_start & r_exc_acc) | r_nexc[1] | w_acc_sum[DWIDTH];

   logic              r_out_valid;
   logic [DWIDTH-1:0] r_c_out;
   logic              r_out_exc;
   logic              r_out_seq_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_acc         <= '0;
         r_exc_acc     <= 1'b0;
         r_seq_err     <= 1'b0;
         r_out_valid   <= 1'b0;
         r_c_out       <= '0;
         r_out_exc     <= 1'b0;
         r_out_seq_err <= 1'b0;
      end else if (!w_stall) begin
         if (w_t_vld) begin
            r_acc     <= w_acc_sum[DWIDTH-1:0];
            r_exc_acc <= w_exc_nxt;
            r_seq_err <= w_err_nxt;
         end
         r_out_valid <= w_t_vld && w_t_last;
         if (w_t_vld && w_t_last) begin
            r_c_out       <= w_acc_sum[DWIDTH-1:0];
            r_out_exc     <= w_exc_nxt;
            r_out_seq_err <= w_err_nxt;
         end
      end
   end

   assign bus.out_valid   = r_out_valid;
   assign bus.C_out       = r_c_out;
   assign bus.out_exc     = r_out_exc;
   assign bus.out_seq_err = r_out_seq_err;
endmodule
`default_nettype wire

// File: tb/tb_tensor_core_mma_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_tensor_core_mma_pipe                                         |
// | Brief    : Directed scoreboard bench for the fp16 MMA pipe (LANES=4).      |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_tensor_core_mma_pipe;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   tensor_core_mma_pipe_if #(.DWIDTH(16), .LANES(4)) bus ();
   tensor_core_mma_pipe #(.DWIDTH(16), .LANES(4)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int          total = 0;
   int          bad   = 0;
   logic [17:0] sb [$];
   logic [17:0] mon_exp;

   task automatic chk_b(input string tag, input logic got, input logic exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic chk_w(input string tag, input logic [15:0] got, input logic [15:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic chk_i(input string tag, input int got, input int exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] rep(input logic [15:0] v);
      return {4{v}};
   endfunction

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic push(input logic [15:0] c, input logic exc, input logic err);
      sb.push_back({c, exc, err});
   endtask

   task automatic send(input logic first, input logic last,
                       input logic [63:0] a, input logic [63:0] b, input logic [15:0] c);
      int n = 0;
      bus.in_valid = 1'b1;
      bus.in_first = first;
      bus.in_last  = last;
      bus.A_in     = a;
      bus.B_in     = b;
      bus.C_in     = c;
      while (bus.in_ready !== 1'b1 && n < 50) begin
         cyc(1);
         n++;
      end
      if (n >= 50) chk_b("in_ready_timeout", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 100) begin
         cyc(1);
         n++;
      end
      chk_i("drain", sb.size(), 0);
   endtask

   always @(negedge clk) begin
      if (rst_n === 1'b1 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
         chk_b("result_expected", sb.size() != 0, 1'b1);
         if (sb.size() != 0) begin
            mon_exp = sb.pop_front();
            chk_w("c_out", bus.C_out, mon_exp[17:2]);
            chk_b("out_exc", bus.out_exc, mon_exp[1]);
            chk_b("out_seq_err", bus.out_seq_err, mon_exp[0]);
         end
      end
   end

   initial begin
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.in_first  = 1'b0;
      bus.in_last   = 1'b0;
      bus.A_in      = '0;
      bus.B_in      = '0;
      bus.C_in      = '0;
      bus.out_ready = 1'b1;
      #1;
      chk_b("rst_out_valid", bus.out_valid, 1'b0);
      chk_w("rst_c_out", bus.C_out, 16'h0000);
      chk_b("rst_out_exc", bus.out_exc, 1'b0);
      chk_b("rst_seq_err", bus.out_seq_err, 1'b0);
      chk_b("rst_in_ready", bus.in_ready, 1'b1);
      cyc(2);
      rst_n = 1'b1;
      cyc(1);

      // single beat 1 + 4*(1*2) = 9, four-edge latency
      push(16'h4880, 1'b0, 1'b0);
      send(1'b1, 1'b1, rep(16'h3C00), rep(16'h4000), 16'h3C00);
      for (int k = 0; k < 4; k++) begin
         chk_b("latency_early", bus.out_valid, 1'b0);
         cyc(1);
      end
      chk_b("latency_n4_valid", bus.out_valid, 1'b1);
      chk_w("latency_n4_data", bus.C_out, 16'h4880);
      drain();

      // two-beat sequence -> 17.0
      push(16'h4C40, 1'b0, 1'b0);
      send(1'b1, 1'b0, rep(16'h3C00), rep(16'h4000), 16'h3C00);
      send(1'b0, 1'b1, rep(16'h3C00), rep(16'h4000), 16'h0000);
      drain();

      // overflow in a lane product
      push(16'h7C00, 1'b1, 1'b0);
      send(1'b1, 1'b1, {48'h0, 16'h7BFF}, {48'h0, 16'h4000}, 16'h0000);
      drain();

      // three back-to-back results with a downstream stall
      bus.out_ready = 1'b0;
      push(16'h4400, 1'b0, 1'b0);
      send(1'b1, 1'b1, rep(16'h3C00), rep(16'h3C00), 16'h0000);
      push(16'h4880, 1'b0, 1'b0);
      send(1'b1, 1'b1, rep(16'h3C00), rep(16'h4000), 16'h3C00);
      push(16'h4500, 1'b0, 1'b0);
      send(1'b1, 1'b1, rep(16'h3C00), rep(16'h3C00), 16'h3C00);
      for (int n = 0; n < 20 && bus.out_valid !== 1'b1; n++) cyc(1);
      chk_b("stall_first_result", bus.out_valid, 1'b1);
      for (int k = 0; k < 5; k++) begin
         chk_b("stall_in_ready", bus.in_ready, 1'b0);
         chk_w("stall_hold", bus.C_out, 16'h4400);
         cyc(1);
      end
      bus.out_ready = 1'b1;
      drain();

      // headless beat in IDLE seeds from +0 and flags a framing error
      push(16'h4400, 1'b0, 1'b1);
      send(1'b0, 1'b1, rep(16'h3C00), rep(16'h3C00), 16'h4000);
      push(16'h4500, 1'b0, 1'b0);
      send(1'b1, 1'b1, rep(16'h3C00), rep(16'h3C00), 16'h3C00);
      drain();

      // first beat mid-sequence restarts with the new seed: 2 + 4 = 6
      push(16'h4600, 1'b0, 1'b1);
      send(1'b1, 1'b0, rep(16'h3C00), rep(16'h3C00), 16'h3C00);
      send(1'b1, 1'b1, rep(16'h3C00), rep(16'h3C00), 16'h4000);
      drain();

      // reset with two beats of an open sequence in flight
      send(1'b1, 1'b0, rep(16'h3C00), rep(16'h4000), 16'h3C00);
      send(1'b0, 1'b0, rep(16'h3C00), rep(16'h4000), 16'h0000);
      rst_n = 1'b0;
      #1;
      chk_b("midrst_out_valid", bus.out_valid, 1'b0);
      chk_w("midrst_c_out", bus.C_out, 16'h0000);
      chk_b("midrst_out_exc", bus.out_exc, 1'b0);
      chk_b("midrst_seq_err", bus.out_seq_err, 1'b0);
      chk_b("midrst_in_ready", bus.in_ready, 1'b1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      cyc(8);
      chk_b("midrst_no_result", bus.out_valid, 1'b0);
      push(16'h4880, 1'b0, 1'b0);
      send(1'b1, 1'b1, rep(16'h3C00), rep(16'h4000), 16'h3C00);
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
`default_nettype wire
